// File: rtl/neuron_sweep_controller.sv
// neuron_sweep_controller: per-tick sequencer for a neuron core.
// On an accepted tick the axon spike vector is latched, then every neuron is
// swept over every axon (integrate strobes), followed by one reg_en per neuron
// and a final done pulse.
// Optional feature macro: NEURON_SWEEP_OVERRUN_EN (sticky overrun flag for
// ticks that arrive while a sweep is in progress; tied to 0 when undefined).
module neuron_sweep_controller #(
  parameter int NUM_NEURONS = 256,
  parameter int NUM_AXONS   = 256,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int AW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NUM_AXONS-1:0] axon_spikes,
  output logic [NW-1:0]        neuron_idx,
  output logic [AW-1:0]        axon_idx,
  output logic                 integrate_en,
  output logic                 reg_en,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_INTEGRATE = 2'd1,
    S_COMMIT    = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [NW-1:0] NEURON_LAST = NW'(NUM_NEURONS - 1);
  localparam logic [AW-1:0] AXON_LAST   = AW'(NUM_AXONS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [NW-1:0]        neuron_q;
  logic [NW-1:0]        neuron_nxt;
  logic [AW-1:0]        axon_q;
  logic [AW-1:0]        axon_nxt;
  logic [NUM_AXONS-1:0] spike_buf;
  logic [NUM_AXONS-1:0] spike_nxt;
  logic                 spike_bit;

  // A single-axon core has a one-bit buffer; select it directly instead of
  // indexing with the (always zero) axon index.
  generate
    if (NUM_AXONS == 1) begin : g_single_axon
      assign spike_bit = spike_buf[0];
    end else begin : g_multi_axon
      assign spike_bit = spike_buf[axon_q];
    end
  endgenerate

  // State, index and spike-buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      neuron_q  <= '0;
      axon_q    <= '0;
      spike_buf <= '0;
    end else begin
      state     <= state_nxt;
      neuron_q  <= neuron_nxt;
      axon_q    <= axon_nxt;
      spike_buf <= spike_nxt;
    end
  end

  // Next-state, index stepping and output decode from registered state only.
  always_comb begin
    state_nxt    = state;
    neuron_nxt   = neuron_q;
    axon_nxt     = axon_q;
    spike_nxt    = spike_buf;
    integrate_en = 1'b0;
    reg_en       = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (tick) begin
          spike_nxt  = axon_spikes;
          neuron_nxt = '0;
          axon_nxt   = '0;
          state_nxt  = S_INTEGRATE;
        end
      end
      S_INTEGRATE: begin
        integrate_en = spike_bit;
        if (axon_q < AXON_LAST) begin
          axon_nxt = axon_q + AW'(1);
        end else begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        reg_en = 1'b1;
        if (neuron_q == NEURON_LAST) begin
          state_nxt = S_DONE;
        end else begin
          neuron_nxt = neuron_q + NW'(1);
          axon_nxt   = '0;
          state_nxt  = S_INTEGRATE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign neuron_idx = neuron_q;
  assign axon_idx   = axon_q;

`ifdef NEURON_SWEEP_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: any tick seen outside IDLE is dropped and recorded here.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (tick && (state != S_IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_sweep_controller.sv
// Self-checking bench for neuron_sweep_controller: a 4x4 instance checked
// against a scoreboard of expected integrate/commit/done events, plus a 1x1
// instance for the degenerate size.
module tb_neuron_sweep_controller;

  localparam int NN = 4;
  localparam int NA = 4;
  localparam int SWEEP_LEN = NN * (NA + 1) + 1;

`ifdef NEURON_SWEEP_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] spikes;
  logic [1:0] neuron_idx;
  logic [1:0] axon_idx;
  logic       integrate_en;
  logic       reg_en;
  logic       busy;
  logic       done;
  logic       overrun;

  logic       tick1;
  logic       spikes1;
  logic       neuron_idx1;
  logic       axon_idx1;
  logic       integrate_en1;
  logic       reg_en1;
  logic       busy1;
  logic       done1;
  logic       overrun1;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int run = 0;
  bit started = 1'b0;

  logic [63:0] iq[$];
  logic [63:0] rq[$];
  logic [63:0] dq[$];

  int ci = 0, cr = 0, cd = 0, cb = 0;
  int ti = 0, tr = 0, td = 0;

  neuron_sweep_controller #(.NUM_NEURONS(NN), .NUM_AXONS(NA)) dut (
    .clk(clk), .rst(rst), .tick(tick), .axon_spikes(spikes),
    .neuron_idx(neuron_idx), .axon_idx(axon_idx),
    .integrate_en(integrate_en), .reg_en(reg_en),
    .busy(busy), .done(done), .overrun(overrun)
  );

  neuron_sweep_controller #(.NUM_NEURONS(1), .NUM_AXONS(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick1), .axon_spikes(spikes1),
    .neuron_idx(neuron_idx1), .axon_idx(axon_idx1),
    .integrate_en(integrate_en1), .reg_en(reg_en1),
    .busy(busy1), .done(done1), .overrun(overrun1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ev(input int c, input int n, input int a);
    return {c[31:0], n[15:0], a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor for the 4x4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      if (busy) run = run + 1;
      else run = 0;
      if (integrate_en && reg_en) check_eq("strobe_overlap", 64'd1, 64'd0);
      if (integrate_en) begin
        if (iq.size() == 0) check_eq("integ_extra", ev(cyc, int'(neuron_idx), int'(axon_idx)), 64'd0);
        else check_eq("integ", ev(cyc, int'(neuron_idx), int'(axon_idx)), iq.pop_front());
      end
      if (reg_en) begin
        if (rq.size() == 0) check_eq("reg_extra", ev(cyc, int'(neuron_idx), int'(axon_idx)), 64'd0);
        else check_eq("reg_en", ev(cyc, int'(neuron_idx), int'(axon_idx)), rq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) check_eq("done_extra", ev(cyc, int'(neuron_idx), int'(axon_idx)), 64'd0);
        else begin
          check_eq("done", ev(cyc, int'(neuron_idx), int'(axon_idx)), dq.pop_front());
          check_eq("busy_len", 64'(run), 64'(SWEEP_LEN));
        end
      end
    end
  end

  // Event recorder for the 1x1 instance.
  always @(negedge clk) begin
    if (started) begin
      if (busy1) cb = cb + 1;
      if (integrate_en1) begin ci = ci + 1; ti = cyc; end
      if (reg_en1) begin cr = cr + 1; tr = cyc; end
      if (done1) begin cd = cd + 1; td = cyc; end
    end
  end

  // Drive a tick now; it is sampled at the next posedge (cycle T), so sweep
  // cycle j is observed while cyc == T + j - 1.
  task automatic start_sweep(input logic [3:0] mask);
    int t;
    t = cyc + 1;
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < NA; a++) begin
        if (mask[a]) iq.push_back(ev(t + n * (NA + 1) + a, n, a));
      end
      rq.push_back(ev(t + n * (NA + 1) + NA, n, NA - 1));
    end
    dq.push_back(ev(t + NN * (NA + 1), NN - 1, NA - 1));
    tick = 1'b1;
    spikes = mask;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!idle) check_eq("timeout", 64'd1, 64'd0);
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_integ_left"}, 64'(iq.size()), 64'd0);
    check_eq({tag, "_reg_left"}, 64'(rq.size()), 64'd0);
    check_eq({tag, "_done_left"}, 64'(dq.size()), 64'd0);
  endtask

  initial begin
    int t1;
    rst = 1'b1;
    tick = 1'b0;
    spikes = 4'h0;
    tick1 = 1'b0;
    spikes1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_state", 64'({integrate_en, reg_en, busy, done, overrun, neuron_idx, axon_idx}), 64'd0);
    started = 1'b1;

    // Full sweep, all spikes.
    start_sweep(4'b1111);
    wait_idle();
    check_drained("sweep1");

    // Back-to-back: tick in the cycle after done.
    start_sweep(4'b1111);
    wait_idle();
    check_drained("b2b");

    // Spike masking, input changes mid-sweep ignored.
    start_sweep(4'b0101);
    spikes = 4'b1111;
    wait_idle();
    check_drained("mask");

    // Overrun: second tick during sweep cycle 5.
    check_eq("overrun_pre", 64'(overrun), 64'd0);
    start_sweep(4'b1111);
    repeat (4) @(posedge clk);
    #1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    wait_idle();
    check_drained("ovr");
    check_eq("overrun_set", 64'(overrun), 64'(EXP_OVR));
    repeat (3) @(posedge clk);
    #1;
    check_eq("overrun_hold", 64'(overrun), 64'(EXP_OVR));
    check_eq("ovr_no_second_sweep", 64'(busy), 64'd0);

    // Reset during sweep cycle 7.
    start_sweep(4'b1111);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    iq.delete();
    rq.delete();
    dq.delete();
    check_eq("abort_state", 64'({integrate_en, reg_en, busy, done, overrun, neuron_idx, axon_idx}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_idle", 64'(busy), 64'd0);
    start_sweep(4'b1111);
    wait_idle();
    check_drained("post_rst");

    // Degenerate 1x1 instance.
    t1 = cyc + 1;
    tick1 = 1'b1;
    spikes1 = 1'b1;
    @(posedge clk);
    #1;
    tick1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("deg_integ_cnt", 64'(ci), 64'd1);
    check_eq("deg_integ_cyc", 64'(ti), 64'(t1));
    check_eq("deg_reg_cnt", 64'(cr), 64'd1);
    check_eq("deg_reg_cyc", 64'(tr), 64'(t1 + 1));
    check_eq("deg_done_cnt", 64'(cd), 64'd1);
    check_eq("deg_done_cyc", 64'(td), 64'(t1 + 2));
    check_eq("deg_busy_len", 64'(cb), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/neuron_sweep_controller.md
# neuron_sweep_controller

Per-tick sequencer for a neuron core. On each `tick` it latches the incoming axon spike vector, then walks every neuron and every axon in order. It emits the indices and integrate strobes used by the neuron datapath, and a one-cycle `reg_en` per neuron. `reg_en` drives the enable of the downstream negedge-sampled potential register, which captures the finished membrane potential for that neuron.

## Interface
Parameters:
- `NUM_NEURONS`, default 256: neurons swept per tick, must be ≥ 1.
- `NUM_AXONS`, default 256: axons integrated per neuron, must be ≥ 1.

Ports:
- `clk` input, 1 bit: single clock, all logic on posedge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `tick` input, 1 bit: one-cycle start pulse.
- `axon_spikes` input, `NUM_AXONS` bits: spike vector, sampled only on an accepted `tick`.
- `neuron_idx` output, `max(1,$clog2(NUM_NEURONS))` bits: current neuron.
- `axon_idx` output, `max(1,$clog2(NUM_AXONS))` bits: current axon.
- `integrate_en` output, 1 bit: add synapse weight for (`neuron_idx`, `axon_idx`).
- `reg_en` output, 1 bit: commit strobe for the downstream potential register.
- `busy` output, 1 bit: sweep in progress.
- `done` output, 1 bit: one-cycle end-of-sweep pulse.
- `overrun` output, 1 bit: sticky flag for a tick that arrived while busy.

## Operation
- States:
  - IDLE: waits for `tick`.
  - INTEGRATE: walks the axons of the current neuron.
  - COMMIT: asserts `reg_en` for the current neuron.
  - DONE: emits `done`.
- IDLE, `tick`=1: latch `axon_spikes` into `spike_buf`, clear both indices to 0, go to INTEGRATE.
- INTEGRATE, every cycle:
  - `integrate_en = spike_buf[axon_idx]`.
  - If `axon_idx` < `NUM_AXONS`-1, increment `axon_idx`.
  - Otherwise hold `axon_idx` and go to COMMIT.
- COMMIT: `reg_en`=1 for exactly one cycle.
  - If `neuron_idx` == `NUM_NEURONS`-1, go to DONE.
  - Otherwise increment `neuron_idx`, clear `axon_idx` to 0, go to INTEGRATE.
- DONE: `done`=1, go to IDLE. `neuron_idx` and `axon_idx` hold their last values until the next accepted tick.
- `busy`=1 in INTEGRATE, COMMIT and DONE.
- `integrate_en` and `reg_en` are 0 in every other state. They are never high in the same cycle.
- `spike_buf` does not change during a sweep. Changes on `axon_spikes` mid-sweep have no effect.
- Indices never exceed their maximum value (`NUM_NEURONS`-1, `NUM_AXONS`-1), so no wrap-around occurs.
- Degenerate sizes:
  - `NUM_AXONS`=1: INTEGRATE lasts one cycle per neuron.
  - `NUM_NEURONS`=1: COMMIT goes straight to DONE.

## Timing
- Reset values, applied at the first posedge with `rst`=1: state IDLE; `neuron_idx`=0, `axon_idx`=0, `spike_buf`=0; `integrate_en`=0, `reg_en`=0, `busy`=0, `done`=0, `overrun`=0.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Sweep latency:
  - Tick accepted at edge T gives INTEGRATE at cycle T+1.
  - `busy` stays high for `NUM_NEURONS`×(`NUM_AXONS`+1)+1 cycles.
  - `done` is high in the last of those cycles.
  - The next tick can be accepted in the cycle after `done`.
- `reg_en` changes on posedge, so it is stable through the following negedge. That negedge is where the downstream register captures.
- A tick while `busy`=1, including in the DONE cycle, is ignored. Handling of `overrun` depends on the configuration below.
- `rst` asserted mid-sweep aborts the sweep at that edge: all reset values apply and no `done` is issued. `rst` takes priority over `tick` in the same cycle.

## Configuration
- Macro: `NEURON_SWEEP_OVERRUN_EN`.
- Defined:
  - An ignored tick sets `overrun` to 1 on the following edge.
  - `overrun` stays set until `rst`.
- Not defined:
  - The `overrun` port still exists and is tied to 0.
  - The flag register is not synthesized.
  - Ignored ticks are silently dropped.

## Test plan
- Sweep timing and order: `NUM_NEURONS`=4, `NUM_AXONS`=4, tick with `axon_spikes`=4'b1111.
  - `busy` high for 21 cycles.
  - 16 `integrate_en` pulses.
  - `reg_en` pulses at `neuron_idx`=0,1,2,3, each following the `axon_idx`=3 cycle.
  - `done` in cycle 21.
- Spike masking: same size, `axon_spikes`=4'b0101, with `axon_spikes` driven to 4'b1111 mid-sweep.
  - `integrate_en` high only at `axon_idx` 0 and 2 for every neuron, 8 pulses in total.
- Overrun:
  - With the macro defined, a second tick in sweep cycle 5 is ignored, the sweep still ends at cycle 21, and `overrun`=1 persists until `rst`.
  - Without the macro, the same stimulus leaves `overrun`=0.
- Reset mid-sweep: assert `rst` at sweep cycle 7.
  - The next cycle shows IDLE with all outputs at reset values and no `done`.
  - A new tick then produces a full 21-cycle sweep.
- Degenerate sizes: `NUM_NEURONS`=1, `NUM_AXONS`=1, tick.
  - `integrate_en`, `reg_en` and `done` each high for one cycle, in consecutive cycles.
  - `busy` high for 3 cycles.
- Back-to-back: tick in the cycle after `done` is accepted, and the second sweep is identical to the first.
